// File: rtl/glitch_cmd_ctrl.sv
// Host command decoder and sequencer for the glitch datapath.
// Decodes configuration writes, control strobes and length-prefixed
// passthrough packets from the host byte stream.
module glitch_cmd_ctrl #(
  parameter int unsigned DELAY_BYTES      = 4,
  parameter int unsigned BOARD_RST_CYCLES = 1200
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic [7:0]               pt_data,
  output logic                     pt_en,
  input  logic                     pt_rdy,
  output logic [7:0]               width,
  output logic [7:0]               pulse_count,
  output logic [8*DELAY_BYTES-1:0] delay,
  output logic                     glitch_arm,
  output logic                     board_rst,
  output logic                     soft_rst,
  output logic                     cmd_err
);

  // Counter holds the remaining high cycles minus one.
  localparam int unsigned CntW = (BOARD_RST_CYCLES > 1) ? $clog2(BOARD_RST_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StCmd, StArg, StPt} state_e;

  state_e          state;
  logic [7:0]      opcode;
  logic [7:0]      len;
  logic [7:0]      hold_data;
  logic            hold_full;
  logic            pt_ok;
  logic [CntW-1:0] brst_cnt;
  logic            pt_send;

  function automatic logic is_delay_op(input logic [7:0] b);
    return (32'(b) >= 32'h20) && (32'(b) < 32'h20 + DELAY_BYTES);
  endfunction

  // Launch the held byte once the transmitter is ready and has cycled rdy since the last strobe.
  always_comb begin
    pt_send = hold_full && pt_rdy && pt_ok;
  end

  // Command FSM, holding register, passthrough strobe and board reset timer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= StIdle;
      opcode      <= 8'h00;
      len         <= 8'h00;
      hold_data   <= 8'h00;
      hold_full   <= 1'b0;
      pt_ok       <= 1'b1;
      brst_cnt    <= '0;
      pt_data     <= 8'h00;
      pt_en       <= 1'b0;
      width       <= 8'h00;
      pulse_count <= 8'h00;
      delay       <= '0;
      glitch_arm  <= 1'b0;
      board_rst   <= 1'b0;
      soft_rst    <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      glitch_arm <= 1'b0;
      soft_rst   <= 1'b0;
      cmd_err    <= 1'b0;
      pt_en      <= 1'b0;

      // A low rdy means the transmitter took the previous byte.
      if (!pt_rdy) pt_ok <= 1'b1;

      if (pt_send) begin
        pt_en     <= 1'b1;
        pt_data   <= hold_data;
        hold_full <= 1'b0;
        pt_ok     <= 1'b0;
      end

      if (board_rst) begin
        if (brst_cnt == '0) board_rst <= 1'b0;
        else                brst_cnt  <= brst_cnt - 1'b1;
      end

      if (rx_valid) begin
        case (state)
          StIdle: begin
            if (rx_data == 8'h00) begin
              state <= StCmd;
            end else begin
              len   <= rx_data;
              state <= StPt;
            end
          end
          StCmd: begin
            state <= StIdle;
            if (rx_data == 8'h00) begin
              glitch_arm <= 1'b1;
            end else if (rx_data == 8'hfe) begin
              // Later assignment restarts an active countdown.
              board_rst <= 1'b1;
              brst_cnt  <= CntW'(BOARD_RST_CYCLES - 1);
            end else if (rx_data == 8'hff) begin
              soft_rst    <= 1'b1;
              width       <= 8'h00;
              pulse_count <= 8'h00;
              delay       <= '0;
            end else if (rx_data == 8'h10 || rx_data == 8'h11 || is_delay_op(rx_data)) begin
              opcode <= rx_data;
              state  <= StArg;
            end else begin
              cmd_err <= 1'b1;
            end
          end
          StArg: begin
            state <= StIdle;
            if (opcode == 8'h10) width <= rx_data;
            if (opcode == 8'h11) pulse_count <= rx_data;
            for (int unsigned k = 0; k < DELAY_BYTES; k++) begin
              if (opcode == 8'(8'h20 + k)) delay[8*k +: 8] <= rx_data;
            end
          end
          StPt: begin
            // Byte overruns a still-occupied holding register: drop it but keep framing.
            if (hold_full && !pt_send) begin
              cmd_err <= 1'b1;
            end else begin
              hold_data <= rx_data;
              hold_full <= 1'b1;
            end
            len <= len - 8'd1;
            if (len == 8'd1) state <= StIdle;
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/glitch_cmd_ctrl.md
Name: glitch_cmd_ctrl

Overview:
- Command decoder and sequencer between the host-side UART receiver and the glitch datapath.
- Parses the host byte stream and does one of three things:
  - writes the glitch configuration registers (width, pulse count, delay);
  - issues control strobes (glitch arm, target-board reset, FPGA soft reset);
  - forwards length-prefixed passthrough packets to the target-side UART transmitter.
- Sits in top between uart_rx (host) and the glitch generator / target uart_tx.

Parameters:
- DELAY_BYTES, 4, number of delay bytes; delay register width = 8*DELAY_BYTES.
- BOARD_RST_CYCLES, 1200, duration of board_rst assertion in clk cycles (100 us at 12 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset (0 = reset).
- rx_data  in  8  byte from host uart_rx.
- rx_valid  in  1  one-cycle strobe; rx_data valid.
- pt_data  out  8  passthrough byte to target uart_tx data_in.
- pt_en  out  1  one-cycle strobe to target uart_tx en.
- pt_rdy  in  1  target uart_tx rdy.
- width  out  8  glitch pulse width, in clk cycles.
- pulse_count  out  8  extra pulses; 0 = single pulse.
- delay  out  8*DELAY_BYTES  trigger-to-glitch delay, in clk cycles.
- glitch_arm  out  1  one-cycle arm strobe to the glitch generator.
- board_rst  out  1  target reset, held high for BOARD_RST_CYCLES.
- soft_rst  out  1  one-cycle FPGA soft-reset strobe.
- cmd_err  out  1  one-cycle strobe on unknown command or passthrough overrun.

Behaviour:
- Reset (rst=0 at posedge): all outputs 0; width=0, pulse_count=0, delay=0; FSM goes to IDLE; holding register empty; board_rst counter cleared. Reset overrides any transfer in progress.
- FSM states: IDLE, CMD, ARG, PT.
- IDLE:
  - rx 0x00 -> CMD.
  - rx nonzero byte L -> latch len=L, go to PT.
- CMD:
  - 0x00 -> glitch_arm=1 next cycle; go to IDLE.
  - 0x10, 0x11, 0x20..0x20+DELAY_BYTES-1 -> latch the opcode; go to ARG.
  - 0xfe -> start board_rst; go to IDLE.
  - 0xff -> soft_rst=1 for one cycle; width, pulse_count and delay cleared; go to IDLE.
  - any other byte -> cmd_err=1; go to IDLE.
- ARG: the next rx byte is written to the register selected by the latched opcode; go to IDLE.
  - 0x10 writes width.
  - 0x11 writes pulse_count.
  - 0x20+k writes delay[8k+7:8k]; other delay bytes unchanged (little-endian).
  - The register updates on the cycle after rx_valid.
- PT:
  - Each rx byte goes into a 1-entry holding register; len decrements.
  - When len reaches 0 after a byte is accepted -> IDLE.
  - A 0x00 byte inside PT is data, not an escape.
- Passthrough output:
  - When the holding register is full and pt_rdy=1: drive pt_data, pulse pt_en for one cycle, clear the holding register.
  - Do not re-issue pt_en until pt_rdy has gone low and high again (one strobe per byte).
  - rx_valid while the holding register is full and not yet accepted: drop the byte, cmd_err=1, len still decrements (framing preserved).
- board_rst:
  - Asserted the cycle after the 0xfe decode; deasserts after exactly BOARD_RST_CYCLES cycles.
  - A second 0xfe while active restarts the count.
  - Independent of the FSM; further commands are processed meanwhile.
- soft_rst does not by itself reset this FSM; top feeds it into rst.
- Strobe latency: glitch_arm, soft_rst and cmd_err are asserted exactly 1 cycle after the triggering rx_valid, and never for 2 consecutive cycles.
- rx_valid is never back-to-back in practice; each valid is still processed independently in a single cycle.

Test Plan:
- Write width then pulse count: rx 00,10,22 then 00,11,05 -> width=0x22, pulse_count=0x05; no strobes; FSM back in IDLE.
- Delay bytes: rx 00,20,32 then 00,21,01 -> delay=0x00000132. Then 00,ff -> soft_rst 1 cycle; width, pulse_count and delay all 0.
- Arm: rx 00,00 -> glitch_arm high exactly 1 cycle, 1 clk after the second rx_valid; width and delay unchanged.
- Passthrough: rx 0e then "Synchronized\r\n" with a uart_tx model on pt_* -> exactly 14 pt_en strobes, bytes in order 53,79,...,0d,0a. Next rx 00 is treated as an escape.
- Board reset: rx 00,fe -> board_rst high for BOARD_RST_CYCLES cycles. A repeated 00,fe at mid-count extends it to BOARD_RST_CYCLES from the second decode. Unknown command 00,42 -> cmd_err 1 cycle; state IDLE.
- Overrun and reset mid-packet:
  - PT with pt_rdy held 0, 2 bytes received -> second dropped, cmd_err=1.
  - rst=0 during a PT of length 5 -> all outputs 0, FSM in IDLE; next byte 00 is decoded as an escape.
